// File: rtl/neuron_lut_loader_if.sv
// Bundle of the configuration stream and lookup port of the neuron table loader.
// No logic; carries the valid/ready config stream and the registered lookup path.
// Backpressure is carried on cfg_ready only; the lookup path never stalls.
interface neuron_lut_loader_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int WORD_W   = 32
);
    logic                cfg_start;
    logic [WORD_W-1:0]   cfg_data;
    logic                cfg_valid;
    logic                cfg_ready;
    logic                cfg_done;
    logic                busy;
    logic [IN_BITS-1:0]  M0;
    logic                in_valid;
    logic [OUT_BITS-1:0] M1;
    logic                out_valid;

    modport master (
        output cfg_start, cfg_data, cfg_valid, M0, in_valid,
        input  cfg_ready, cfg_done, busy, M1, out_valid
    );

    modport slave (
        input  cfg_start, cfg_data, cfg_valid, M0, in_valid,
        output cfg_ready, cfg_done, busy, M1, out_valid
    );
endinterface

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable 2^IN_BITS x OUT_BITS neuron truth table with registered lookup.
// Lookup latency 1 cycle; a full load takes LOAD_WORDS accepted words plus one DONE cycle.
// cfg_ready high only while loading; lookups issued while busy are dropped, not queued.
module neuron_lut_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int WORD_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    neuron_lut_loader_if.slave bus
);
    localparam int DEPTH      = 1 << IN_BITS;
    localparam int EPW        = WORD_W / OUT_BITS;
    localparam int LOAD_WORDS = (DEPTH * OUT_BITS) / WORD_W;
    localparam int CNT_W      = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE, READY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    word_cnt;
    logic                table_valid;
    logic [OUT_BITS-1:0] lut [DEPTH];

    logic                ready;
    logic                done;
    logic                busy_w;
    logic                cnt_clr;
    logic                set_valid;
    logic                clr_valid;
    logic                wr_en;
    logic                lookup_acc;
    logic [OUT_BITS-1:0] m1_q;
    logic                out_valid_q;

    // Next-state and control decode; cfg_start is ignored while a load is in flight.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        busy_w    = 1'b0;
        cnt_clr   = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        case (state)
            IDLE: begin
                clr_valid = 1'b1;
                if (bus.cfg_start) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                end
            end
            LOAD: begin
                ready  = 1'b1;
                busy_w = 1'b1;
                if (bus.cfg_valid && (word_cnt == CNT_W'(LOAD_WORDS - 1)))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                busy_w    = 1'b1;
                set_valid = 1'b1;
                state_nxt = READY;
            end
            READY: begin
                // A lookup in this same cycle still sees the old table and table_valid.
                if (bus.cfg_start) begin
                    state_nxt = LOAD;
                    cnt_clr   = 1'b1;
                    clr_valid = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_en      = ready && bus.cfg_valid;
    assign lookup_acc = bus.in_valid && !busy_w;

    assign bus.cfg_ready = ready;
    assign bus.cfg_done  = done;
    assign bus.busy      = busy_w;
    assign bus.M1        = m1_q;
    assign bus.out_valid = out_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Word counter and table-valid flag; reset hides any partially written contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt    <= '0;
            table_valid <= 1'b0;
        end else begin
            if (cnt_clr)    word_cnt <= '0;
            else if (wr_en) word_cnt <= word_cnt + 1'b1;
            if (clr_valid)      table_valid <= 1'b0;
            else if (set_valid) table_valid <= 1'b1;
        end
    end

    // Table write: all EPW entries of an accepted word land in one cycle (banked LUTRAM).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < EPW; k++)
                lut[IN_BITS'(int'(word_cnt) * EPW + k)] <= bus.cfg_data[k*OUT_BITS +: OUT_BITS];
        end
    end

    // Registered lookup; M1 holds its last value when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            m1_q        <= '0;
        end else begin
            out_valid_q <= lookup_acc;
            if (lookup_acc)
                m1_q <= table_valid ? lut[bus.M0] : '0;
        end
    end
endmodule

// File: tb/tb_neuron_lut_loader.sv
// Directed bench for neuron_lut_loader: reset, load timing, backpressure, lookups.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Expected values are written out by hand per scenario.
module tb_neuron_lut_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_lut_loader_if bus();

    neuron_lut_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] words [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: table invalid; 1: 3D..3F = 01; 2: 00..0F = 11
    function automatic logic [1:0] exp_val(input int mode, input int a);
        case (mode)
            1:       return (a >= 'h3D && a <= 'h3F) ? 2'b01 : 2'b00;
            2:       return (a < 16) ? 2'b11 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    task automatic lookup(input string tag, input logic [7:0] addr, input logic [1:0] exp);
        bus.M0       = addr;
        bus.in_valid = 1'b1;
        step;
        bus.in_valid = 1'b0;
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_m1"}, bus.M1, exp);
    endtask

    task automatic sweep(input int mode);
        for (int i = 0; i < 256; i++) begin
            bus.M0       = 8'(i);
            bus.in_valid = 1'b1;
            step;
            chk($sformatf("sweep_vld_%0h", i), bus.out_valid, 1);
            chk($sformatf("sweep_m1_%0h", i), bus.M1, exp_val(mode, i));
        end
        bus.in_valid = 1'b0;
        step;
        chk("sweep_tail_vld", bus.out_valid, 0);
    endtask

    task automatic do_load(input bit toggle, input bit hold_lk, input bit start_lk,
                           input logic [1:0] start_exp);
        int cnt = 0;
        int cyc = 1;
        bit acc;
        bus.cfg_start = 1'b1;
        if (start_lk) begin
            bus.M0       = 8'h3F;
            bus.in_valid = 1'b1;
        end
        step;
        bus.cfg_start = 1'b0;
        bus.in_valid  = 1'b0;
        if (start_lk) begin
            chk("start_lk_vld", bus.out_valid, 1);
            chk("start_lk_m1", bus.M1, start_exp);
        end
        if (hold_lk) begin
            bus.M0       = 8'h3D;
            bus.in_valid = 1'b1;
        end
        chk("load_busy", bus.busy, 1);
        chk("load_rdy", bus.cfg_ready, 1);
        chk("load_nodone", bus.cfg_done, 0);
        while (cnt < 16 && cyc < 100) begin
            bus.cfg_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            bus.cfg_data  = bus.cfg_valid ? words[cnt] : 32'hFFFF_FFFF;
            acc = bus.cfg_valid && bus.cfg_ready;
            step;
            if (acc) cnt++;
            cyc++;
            if (hold_lk) chk("lk_in_load", bus.out_valid, 0);
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 32'h0;
        chk("load_accepts", cnt, 16);
        chk("load_cycles", cyc, toggle ? 32 : 17);
        chk("done_pulse", bus.cfg_done, 1);
        chk("done_busy", bus.busy, 1);
        chk("done_rdy", bus.cfg_ready, 0);
        step;
        chk("ready_nodone", bus.cfg_done, 0);
        chk("ready_busy", bus.busy, 0);
        if (hold_lk) chk("lk_in_done", bus.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_data  = 32'h0;
        bus.cfg_valid = 1'b0;
        bus.M0        = 8'h0;
        bus.in_valid  = 1'b0;
        step;
        step;
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_cfg_done", bus.cfg_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_m1", bus.M1, 0);
        rst = 1'b0;

        // Lookup straight after reset: table invalid.
        lookup("post_rst", 8'h3D, 2'b00);
        step;
        chk("post_rst_idle_vld", bus.out_valid, 0);

        // Full load with word 3 = 5400_0000 -> 3D..3F = 01.
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        words[3] = 32'h5400_0000;
        do_load(1'b0, 1'b0, 1'b0, 2'b00);
        sweep(1);

        // Same load with cfg_valid toggling; garbage on idle cycles must not land.
        do_load(1'b1, 1'b0, 1'b0, 2'b00);
        sweep(1);

        // Lookups held through LOAD and DONE are dropped.
        do_load(1'b0, 1'b1, 1'b0, 2'b00);
        step;
        bus.in_valid = 1'b0;
        chk("lk_first_ready_vld", bus.out_valid, 1);
        chk("lk_first_ready_m1", bus.M1, 2'b01);
        step;

        // Reset after the 7th word of a partial load of AAAA_AAAA.
        bus.cfg_start = 1'b1;
        step;
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 32'hAAAA_AAAA;
        for (int i = 0; i < 7; i++) step;
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        step;
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rdy", bus.cfg_ready, 0);
        lookup("midrst_3d", 8'h3D, 2'b00);
        lookup("midrst_00", 8'h00, 2'b00);
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        words[0] = 32'hFFFF_FFFF;
        do_load(1'b0, 1'b0, 1'b0, 2'b00);
        sweep(2);

        // Reload from READY with a concurrent lookup: A then B.
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        words[3] = 32'h5400_0000;
        do_load(1'b0, 1'b0, 1'b0, 2'b00);
        words[3] = 32'hC000_0000;
        do_load(1'b0, 1'b0, 1'b1, 2'b01);
        lookup("tblb_3f", 8'h3F, 2'b11);
        lookup("tblb_3d", 8'h3D, 2'b00);

        // rst together with cfg_start: reset wins, stays idle, table hidden.
        rst           = 1'b1;
        bus.cfg_start = 1'b1;
        step;
        rst           = 1'b0;
        bus.cfg_start = 1'b0;
        chk("rst_start_busy", bus.busy, 0);
        chk("rst_start_rdy", bus.cfg_ready, 0);
        step;
        chk("rst_start_idle", bus.busy, 0);
        lookup("rst_start_3f", 8'h3F, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_lut_loader.md
# neuron_lut_loader

Runtime-programmable neuron truth table for LogicNets layers. It stores a 256-entry × 2-bit table in distributed RAM, loaded over a 32-bit valid/ready configuration stream, and answers registered lookups with the same M0 → M1 mapping as the generated fixed-ROM neurons. It is the writer side of the table: the same 8-bit input code / 2-bit output function, filled in at run time instead of frozen at synthesis, for on-board weight updates and hardware-in-loop checks.

## Interface
- IN_BITS, 8, lookup address width; the table depth is 2^IN_BITS.
- OUT_BITS, 2, output width of each table entry.
- WORD_W, 32, configuration word width; each word carries WORD_W/OUT_BITS = 16 entries.
- Derived: LOAD_WORDS = 2^IN_BITS·OUT_BITS/WORD_W = 16.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse that begins a full table load.
- cfg_data  in  WORD_W  packed entries.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block accepts cfg_data; high only in LOAD.
- cfg_done  out  1  one-cycle pulse when the last word has been written.
- busy  out  1  high in LOAD and DONE.
- M0  in  IN_BITS  lookup code, interpreted as an unsigned address.
- in_valid  in  1  lookup request.
- M1  out  OUT_BITS  registered lookup result.
- out_valid  out  1  M1 is valid.

## Operation
- **States:** IDLE, LOAD, DONE, READY. Reset enters IDLE.
- **IDLE:**
  - table_valid = 0.
  - cfg_start → LOAD, word_cnt = 0.
- **READY:**
  - cfg_start → LOAD, word_cnt = 0, table_valid cleared in the same cycle.
- **LOAD:**
  - cfg_ready = 1.
  - On cfg_valid & cfg_ready, entry k (k = 0..15) is written to address word_cnt·16 + k with value cfg_data[2k+1:2k]; then word_cnt increments.
  - Accepting word 15 → DONE.
  - cfg_start is ignored in LOAD.
- **DONE:**
  - One cycle: cfg_done = 1, table_valid set, → READY.
- **Write mechanics:**
  - The RAM writes 16 entries per accepted word, in one cycle.
  - A 16-wide write port, banked as 16 × (16×2) LUTRAMs indexed by M0[3:0], is acceptable.
- **Lookup:**
  - Accepted only when busy = 0.
  - M1 = table_valid ? table[M0] : 0.
  - in_valid while busy is dropped: no out_valid, no queuing.
- The table contents are not reset. table_valid gates every output, so stale contents are never visible after rst.

## Timing
- Reset values: cfg_ready 0, cfg_done 0, busy 0, M1 2'b00, out_valid 0, table_valid 0, word_cnt 0.
- Lookup latency: 1 cycle. in_valid at cycle t gives out_valid and M1 at t+1. Full throughput, one lookup per cycle, with no bubbles in IDLE or READY.
- Load duration: with cfg_valid held high, cfg_start at t, words accepted at t+1..t+16, cfg_done at t+17, lookups accepted from t+18.
- Backpressure: cfg_valid gaps stall word_cnt without limit. There is no timeout.
- Simultaneous events:
  - cfg_start and in_valid in the same READY cycle: the lookup completes normally with the old table (out_valid at the next cycle), then LOAD starts.
  - cfg_start in IDLE/READY together with rst: rst wins.
- Reset mid-load: the next cycle is IDLE, table_valid 0, and any partial writes are hidden. A later load must rewrite all 16 words.
- out_valid and M1 are registered. M1 holds its last value when out_valid = 0.

## Test plan
- **Reset, then lookup:** rst, then M0 = 8'h3D with in_valid → out_valid = 1 next cycle, M1 = 2'b00 (table invalid).
- **Full load, then sweep:**
  - Stimulus: cfg_start, then 16 words, all 0 except word 3 = 32'h5400_0000.
  - Required: cfg_done pulses exactly at t+17.
  - Sweep M0 = 0..255 back-to-back → M1 = 2'b01 only for 8'h3D, 8'h3E, 8'h3F, otherwise 2'b00; 256 consecutive out_valid.
- **Backpressure:** same load with cfg_valid toggling every other cycle → 16 accepts, cfg_done at the cycle after the 16th accept; readback identical to the full-load scenario.
- **Lookup during load:** in_valid held high through LOAD and DONE → out_valid stays 0 until the cycle after the first READY-cycle request.
- **Reset mid-load:** rst after the 7th word → busy 0, lookups return 0. A full reload with word 0 = 32'hFFFF_FFFF → M0 = 0..15 give 2'b11, M0 = 8'h3D gives 2'b00 (the new contents, not a mix).
- **Reload from READY:** load table A, then cfg_start with concurrent in_valid (M0 = 8'h3F) → that lookup returns A's value. A lookup after the next cfg_done returns table B's value.
